rnn_mvm_engine: RTL
===================

# rnn_mvm_engine

Parametrised matrix-vector multiply engine for the RNN accelerator. It holds a ROWS×COLS signed fixed-point weight matrix and a COLS-element input vector, loaded through the accelerator's 32-bit memory-mapped slave port. On a start command it computes y = act(W·x) with one multiply-accumulate per clock, and exposes the results through an auto-incrementing read window. It generalises the fixed 2×4 / 4×4 weight stores by adding sizing parameters, a compute sequencer, saturation and a selectable activation.

## Interface
- ROWS, default 4: matrix rows and result count (1..256).
- COLS, default 4: matrix columns and vector length (1..256).
- FRAC, default 8: fractional bits of the signed 16-bit Q format (0..15).
- clk  in  1  the single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- read  in  1  read strobe, sampled on the rising edge.
- write  in  1  write strobe, sampled on the rising edge.
- addr  in  32  word address; only values 0–4 are mapped.
- data_in  in  32  write data.
- data_out  out  32  registered read data.

## Operation
- Address 0, CTRL/STATUS:
  - Write bit0=1 issues start. Write bit1=1 clears done.
  - Read returns {30'b0, done, busy}.
- Address 1, vector write: data_in = {idx[15:0], value[15:0]} sets x[idx]=value. Writes with idx ≥ COLS are ignored.
- Address 2, matrix write: data_in = {row[7:0], col[7:0], value[15:0]} sets W[row][col]. Out-of-range writes are ignored.
- Address 3, result window:
  - Write sets ptr = data_in[7:0]; values ≥ ROWS are ignored.
  - Read returns sign-extended y[ptr], then ptr increments and wraps from ROWS-1 to 0.
- Address 4, MODE:
  - Write data_in[1:0] selects the activation: 00 none, 01 ReLU, 10 hard-tanh, 11 treated as none.
  - Read returns {30'b0, mode}.
- Unmapped reads return 0. Unmapped writes are no-ops.
- FSM states:
  - IDLE: on start, go to MAC with r=0, c=0, acc=0, busy=1, done=0.
  - MAC: acc += W[r][c]·x[c]; c increments. After c=COLS-1, go to WB.
  - WB: y[r] = act(sat(acc>>>FRAC)); acc=0, c=0. If r=ROWS-1, go to IDLE with busy=0, done=1; otherwise r increments and the FSM returns to MAC.
- Arithmetic:
  - Each product is a signed 32-bit value.
  - acc is 32+$clog2(COLS)+1 bits and never wraps.
  - >>> is an arithmetic shift, so it truncates toward −∞.
  - sat clamps to [−32768, 32767].
  - Hard-tanh clamps to [−(1<<FRAC), (1<<FRAC)]. ReLU maps negative values to 0.
- While busy:
  - Writes to addresses 1, 2 and 4 are ignored, and start is ignored.
  - Writes to address 0 bit1, address 3 and all reads are still served. A y read while busy returns the previous result.
- done is sticky until a clear or a new start. Start with bit1 also set results in done=0 and busy=1.

## Timing
- Reset (asynchronous, any state, including mid-computation): FSM→IDLE; busy=0, done=0, ptr=0, mode=0, data_out=0; all W, x and y are zeroed.
- Write latency:
  - Register writes are visible one edge after the strobe.
  - A vector or matrix element written at edge T can be read back via internal state after T.
- Read latency: one cycle. data_out is updated on the edge that samples read and holds until the next read.
- Same-edge write and read to one address: the read returns the pre-write value. At address 3, the written ptr wins over the increment.
- Compute latency:
  - If start is sampled at edge T, busy=1 after T.
  - busy falls and done rises after edge T + ROWS·(COLS+1).
  - Default sizing gives 20 cycles.
- Back-to-back start: a start sampled on the same edge where the FSM enters IDLE is ignored, because busy is still 1 at sampling. A start one cycle later is accepted.

## Test plan
- Integer load, FRAC=0, ROWS=2, COLS=4, mode 00:
  - Stimulus: W row0 = [2,−10,−10,3], row1 = [6,9,12,1], x = [2,−3,0,0], then start.
  - Required: busy for exactly 10 cycles; done=1; reads at address 3 return 34 then 0xFFFFFFF1 (−15); ptr wraps so a third read returns 34.
- ReLU: same data with mode 01 → y = [34, 0]. Hard-tanh with FRAC=8, W[0][0]=0x0300 (3.0), x[0]=0x0100 (1.0) → y[0] = 0x0100.
- Saturation, FRAC=0:
  - W[0][0]=32767, x[0]=2 → y[0]=32767.
  - W[0][0]=−32768, x[0]=2 → y[0]=−32768, read as 0xFFFF8000.
- Busy protection: during a computation, write W[0][0]=99 and start again → W is unchanged, the latency is unchanged, and the result matches the pre-write weights.
- Out-of-range writes: vector idx=COLS, matrix row=ROWS, and ptr=ROWS are all ignored; STATUS is unchanged and unmapped address 7 reads 0.
- Reset mid-computation: assert rst_n=0 five cycles after start → busy=0, done=0, and all y reads return 0. A full reload and start then gives correct results.

Source files
------------

// File: rtl/rnn_mvm_engine.sv
// Matrix-vector multiply engine: y = act(sat((W*x) >>> FRAC)), one MAC per clock,
// loaded and read back through a 32-bit word-addressed slave port.
module rnn_mvm_engine #(
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4,
    parameter int unsigned FRAC = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out
);

    localparam int unsigned AW = 32 + $clog2(COLS) + 1;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic signed [AW-1:0] SAT_MAX = AW'(32'sd32767);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-32'sd32768);
    localparam int HT_MAX = 1 << FRAC;

    typedef enum logic [1:0] {IDLE, MAC, WB} state_t;

    state_t state_q, state_d;

    logic signed [15:0]   w_q [ROWS][COLS];
    logic signed [15:0]   x_q [COLS];
    logic signed [15:0]   y_q [ROWS];
    logic signed [AW-1:0] acc_q;
    logic [RW-1:0]        r_q;
    logic [RW-1:0]        ptr_q;
    logic [CW-1:0]        c_q;
    logic [1:0]           mode_q;
    logic                 done_q;

    logic                 busy_c, start_c, mac_en_c, wb_en_c, last_col_c, last_row_c;
    logic                 wr_ctrl_c, wr_vec_c, wr_mat_c, wr_ptr_c, wr_mode_c, rd_ptr_c;
    logic signed [31:0]   prod_c;
    logic signed [AW-1:0] shifted_c;
    logic signed [15:0]   sat_c;
    logic signed [31:0]   sat_ext_c;
    logic signed [15:0]   act_c;
    logic [31:0]          rdata_c;

    // Bus decode; range checks for vector/matrix/pointer targets live here.
    always_comb begin
        wr_ctrl_c = write && (addr == 32'd0);
        wr_vec_c  = write && (addr == 32'd1) && (32'(data_in[31:16]) < COLS);
        wr_mat_c  = write && (addr == 32'd2) && (32'(data_in[31:24]) < ROWS)
                          && (32'(data_in[23:16]) < COLS);
        wr_ptr_c  = write && (addr == 32'd3) && (32'(data_in[7:0]) < ROWS);
        wr_mode_c = write && (addr == 32'd4);
        rd_ptr_c  = read  && (addr == 32'd3);
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Sequencer next state and step enables; start is only honoured from IDLE.
    always_comb begin
        state_d    = state_q;
        busy_c     = (state_q != IDLE);
        start_c    = 1'b0;
        mac_en_c   = 1'b0;
        wb_en_c    = 1'b0;
        last_col_c = (c_q == CW'(COLS - 1));
        last_row_c = (r_q == RW'(ROWS - 1));
        case (state_q)
            IDLE: begin
                start_c = wr_ctrl_c && data_in[0];
                if (start_c) state_d = MAC;
            end
            MAC: begin
                mac_en_c = 1'b1;
                if (last_col_c) state_d = WB;
            end
            WB: begin
                wb_en_c = 1'b1;
                state_d = last_row_c ? IDLE : MAC;
            end
            default: state_d = IDLE;
        endcase
    end

    // Product, scaling, saturation and activation of the accumulated row.
    always_comb begin
        prod_c    = 32'(w_q[r_q][c_q]) * 32'(x_q[c_q]);
        shifted_c = acc_q >>> FRAC;
        if (shifted_c > SAT_MAX)      sat_c = 16'sh7fff;
        else if (shifted_c < SAT_MIN) sat_c = 16'sh8000;
        else                          sat_c = 16'(shifted_c);
        sat_ext_c = 32'(sat_c);
        act_c     = sat_c;
        case (mode_q)
            2'b01: if (sat_c < 16'sd0) act_c = 16'sd0;
            2'b10: begin
                if (sat_ext_c > HT_MAX)       act_c = 16'(HT_MAX);
                else if (sat_ext_c < -HT_MAX) act_c = 16'(-HT_MAX);
            end
            default: act_c = sat_c;
        endcase
    end

    // Read mux; y is sign-extended to the bus width.
    always_comb begin
        rdata_c = '0;
        case (addr)
            32'd0:   rdata_c = {30'b0, done_q, busy_c};
            32'd3:   rdata_c = 32'(y_q[ptr_q]);
            32'd4:   rdata_c = {30'b0, mode_q};
            default: rdata_c = '0;
        endcase
    end

    // Compute datapath: accumulator, row/column counters, result write-back, done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            r_q    <= '0;
            c_q    <= '0;
            done_q <= 1'b0;
            for (int i = 0; i < ROWS; i++) y_q[i] <= '0;
        end else begin
            if (start_c) begin
                acc_q  <= '0;
                r_q    <= '0;
                c_q    <= '0;
                done_q <= 1'b0;
            end else if (wr_ctrl_c && data_in[1]) begin
                done_q <= 1'b0;
            end
            if (mac_en_c) begin
                acc_q <= acc_q + AW'(prod_c);
                c_q   <= last_col_c ? '0 : c_q + CW'(1);
            end
            if (wb_en_c) begin
                y_q[r_q] <= act_c;
                acc_q    <= '0;
                c_q      <= '0;
                if (last_row_c) done_q <= 1'b1;
                else            r_q    <= r_q + RW'(1);
            end
        end
    end

    // Operand stores and mode; frozen while a computation is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= '0;
            for (int j = 0; j < COLS; j++) x_q[j] <= '0;
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) w_q[i][j] <= '0;
        end else if (!busy_c) begin
            if (wr_vec_c)  x_q[CW'(data_in[31:16])] <= data_in[15:0];
            if (wr_mat_c)  w_q[RW'(data_in[31:24])][CW'(data_in[23:16])] <= data_in[15:0];
            if (wr_mode_c) mode_q <= data_in[1:0];
        end
    end

    // Result window pointer and registered read data; a pointer write beats the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            data_out <= '0;
        end else begin
            if (wr_ptr_c)      ptr_q <= RW'(data_in[7:0]);
            else if (rd_ptr_c) ptr_q <= (ptr_q == RW'(ROWS - 1)) ? '0 : ptr_q + RW'(1);
            if (read) data_out <= rdata_c;
        end
    end

endmodule
